mem_stage: RTL and testbench

//  MEM pipeline stage: consumes the EX/MEM register outputs, performs loads/stores on the

---
 rtl/mem_stage.sv | 164 ++++++++++++++++
 tb/tb_mem_stage.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores on a req/ack data bus, stalls
// upstream while a transfer is outstanding, and registers the MEM/WB slot.
module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  input  logic        wmem,
  input  logic        rmem,
  output logic        stall_req,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        bus_err
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] sdata_q, sdata_d;
  logic        wbv_q, wbv_d;
  logic [4:0]  wbwd_q, wbwd_d;
  logic        wbwr_q, wbwr_d;
  logic [31:0] wbdat_q, wbdat_d;
  logic        err_q, err_d;
  logic        stall;

  logic memop;
  logic bad;

  assign memop = in_valid & (rmem | wmem);
  assign bad   = memop & ((rmem & wmem) | (mem_addr[1:0] != 2'b00));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    sdata_d = sdata_q;
    wbv_d   = 1'b0;
    wbwd_d  = wbwd_q;
    wbwr_d  = wbwr_q;
    wbdat_d = wbdat_q;
    err_d   = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!in_valid) begin
          wbwr_d = 1'b0;
        end else if (!memop) begin
          wbv_d   = 1'b1;
          wbwd_d  = mem_wd;
          wbwr_d  = mem_wreg;
          wbdat_d = mem_wdata;
        end else if (bad) begin
          // Faulting access retires as a NOP so the pipe keeps moving
          err_d   = 1'b1;
          wbv_d   = 1'b1;
          wbwd_d  = mem_wd;
          wbwr_d  = 1'b0;
          wbdat_d = '0;
        end else begin
          stall   = 1'b1;
          req_d   = 1'b1;
          we_d    = wmem;
          addr_d  = mem_addr;
          sdata_d = mem_wdata;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (dbus_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
          wbv_d   = 1'b1;
          wbwd_d  = mem_wd;
          if (we_q) begin
            wbdat_d = '0;
            wbwr_d  = 1'b0;
          end else begin
            wbdat_d = dbus_rdata;
            wbwr_d  = mem_wreg;
          end
        end else if (cnt_q == TMO_LAST) begin
          req_d   = 1'b0;
          state_d = IDLE;
          err_d   = 1'b1;
          wbv_d   = 1'b1;
          wbwd_d  = mem_wd;
          wbwr_d  = 1'b0;
          wbdat_d = '0;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      sdata_q <= '0;
      wbv_q   <= 1'b0;
      wbwd_q  <= '0;
      wbwr_q  <= 1'b0;
      wbdat_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      wbv_q   <= wbv_d;
      wbwd_q  <= wbwd_d;
      wbwr_q  <= wbwr_d;
      wbdat_q <= wbdat_d;
      err_q   <= err_d;
    end
  end

  // Stall is combinational; mask it so reset forces every output low at once
  assign stall_req  = stall & ~rst;
  assign dbus_req   = req_q;
  assign dbus_we    = we_q;
  assign dbus_addr  = addr_q;
  assign dbus_wdata = sdata_q;
  assign wb_valid   = wbv_q;
  assign wb_wd      = wbwd_q;
  assign wb_wreg    = wbwr_q;
  assign wb_wdata   = wbdat_q;
  assign bus_err    = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus random ops checked
// against a rule-level latency/result model.
module tb_mem_stage;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;
  logic        wmem;
  logic        rmem;
  logic        stall_req;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic        wb_valid;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        bus_err;

  int n_chk = 0;
  int n_err = 0;

  int          o_lat, o_stc, o_rqc;
  logic        o_err, o_stable, o_wreg, o_rwe;
  logic        o_wv_after, o_err_after, o_req_after;
  logic [4:0]  o_wd;
  logic [31:0] o_wdata, o_raddr, o_rwdata;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
    .mem_wdata(mem_wdata), .mem_addr(mem_addr),
    .wmem(wmem), .rmem(rmem),
    .stall_req(stall_req),
    .dbus_req(dbus_req), .dbus_we(dbus_we),
    .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
    .wb_valid(wb_valid), .wb_wd(wb_wd), .wb_wreg(wb_wreg),
    .wb_wdata(wb_wdata), .bus_err(bus_err)
  );

  // Drives one instruction, acts as the bus slave (ack after `waits`
  // request cycles), and records what the stage did. Called at posedge+1.
  task automatic run_op(input logic v, rm, wm, wr,
                        input logic [4:0] wd,
                        input logic [31:0] wdat, ad, rd,
                        input int waits);
    in_valid = v; rmem = rm; wmem = wm; mem_wreg = wr;
    mem_wd = wd; mem_wdata = wdat; mem_addr = ad; dbus_rdata = rd;
    o_lat = 0; o_stc = 0; o_rqc = 0; o_err = 0; o_stable = 1;
    o_wd = 0; o_wreg = 0; o_wdata = 0;
    o_raddr = 0; o_rwe = 0; o_rwdata = 0;
    for (int c = 1; c <= 40 && o_lat == 0; c++) begin
      #4;
      dbus_ack = dbus_req && (o_rqc == waits);
      #1;
      if (stall_req) o_stc++;
      if (dbus_req) begin
        if (o_rqc == 0) begin
          o_raddr = dbus_addr; o_rwe = dbus_we; o_rwdata = dbus_wdata;
        end else if (dbus_addr !== o_raddr || dbus_we !== o_rwe ||
                     dbus_wdata !== o_rwdata) begin
          o_stable = 0;
        end
        o_rqc++;
      end
      @(posedge clk); #1;
      dbus_ack = 1'b0;
      if (wb_valid) begin
        o_lat = c; o_err = bus_err;
        o_wd = wb_wd; o_wreg = wb_wreg; o_wdata = wb_wdata;
      end
    end
    in_valid = 0; rmem = 0; wmem = 0;
    @(posedge clk); #1;
    o_wv_after = wb_valid; o_err_after = bus_err; o_req_after = dbus_req;
  endtask

  task automatic test_reset;
    rst = 1; in_valid = 0; rmem = 0; wmem = 0; mem_wreg = 0;
    mem_wd = 0; mem_wdata = 0; mem_addr = 0; dbus_ack = 0; dbus_rdata = 0;
    #2;
    n_chk++;
    if ({stall_req, dbus_req, dbus_we, dbus_addr, dbus_wdata, wb_valid,
         wb_wd, wb_wreg, wb_wdata, bus_err} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got req=%b stall=%b wbv=%b err=%b, need all 0",
               dbus_req, stall_req, wb_valid, bus_err);
    end
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_alu;
    run_op(1, 0, 0, 1, 5'd3, 32'h1234, 32'h0, 32'h0, 0);
    n_chk++;
    if (o_lat !== 1 || o_wd !== 5'd3 || o_wreg !== 1'b1) begin
      n_err++;
      $display("FAIL alu_retire: lat=%0d wd=%0d wreg=%b, need 1/3/1",
               o_lat, o_wd, o_wreg);
    end
    n_chk++;
    if (o_wdata !== 32'h1234) begin
      n_err++;
      $display("FAIL alu_wdata: got %h need 00001234", o_wdata);
    end
    n_chk++;
    if (o_stc != 0 || o_rqc != 0) begin
      n_err++;
      $display("FAIL alu_nostall: stall=%0d req=%0d cycles, need 0/0", o_stc, o_rqc);
    end
    n_chk++;
    if (o_wv_after !== 1'b0 || wb_wreg !== 1'b0) begin
      n_err++;
      $display("FAIL idle_clears: wbv=%b wreg=%b, need 0/0", o_wv_after, wb_wreg);
    end
  endtask

  task automatic test_load;
    run_op(1, 1, 0, 1, 5'd7, 32'h0, 32'h100, 32'hDEADBEEF, 0);
    n_chk++;
    if (o_lat !== 2 || o_stc != 1 || o_rqc != 1) begin
      n_err++;
      $display("FAIL load_timing: lat=%0d stall=%0d req=%0d, need 2/1/1",
               o_lat, o_stc, o_rqc);
    end
    n_chk++;
    if (o_rwe !== 1'b0 || o_raddr !== 32'h100) begin
      n_err++;
      $display("FAIL load_bus: we=%b addr=%h, need 0/00000100", o_rwe, o_raddr);
    end
    n_chk++;
    if (o_wdata !== 32'hDEADBEEF || o_wreg !== 1'b1 || o_wd !== 5'd7) begin
      n_err++;
      $display("FAIL load_wb: data=%h wreg=%b wd=%0d, need deadbeef/1/7",
               o_wdata, o_wreg, o_wd);
    end
  endtask

  task automatic test_store;
    run_op(1, 0, 1, 1, 5'd9, 32'hA5A5A5A5, 32'h20, 32'h0, 3);
    n_chk++;
    if (o_rqc != 4 || o_stc != 4 || o_lat !== 5) begin
      n_err++;
      $display("FAIL store_timing: req=%0d stall=%0d lat=%0d, need 4/4/5",
               o_rqc, o_stc, o_lat);
    end
    n_chk++;
    if (!o_stable || o_rwe !== 1'b1 || o_raddr !== 32'h20 ||
        o_rwdata !== 32'hA5A5A5A5) begin
      n_err++;
      $display("FAIL store_bus: stable=%b we=%b addr=%h wdata=%h",
               o_stable, o_rwe, o_raddr, o_rwdata);
    end
    n_chk++;
    if (o_wreg !== 1'b0 || o_wv_after !== 1'b0 || o_req_after !== 1'b0) begin
      n_err++;
      $display("FAIL store_wb: wreg=%b wbv_after=%b req_after=%b, need 0/0/0",
               o_wreg, o_wv_after, o_req_after);
    end
  endtask

  task automatic test_bad;
    run_op(1, 1, 0, 1, 5'd4, 32'h0, 32'h102, 32'h0, 0);
    n_chk++;
    if (o_rqc != 0 || o_stc != 0 || o_lat !== 1 || o_err !== 1'b1 ||
        o_wreg !== 1'b0 || o_err_after !== 1'b0) begin
      n_err++;
      $display("FAIL misaligned: req=%0d stall=%0d lat=%0d err=%b wreg=%b err_after=%b",
               o_rqc, o_stc, o_lat, o_err, o_wreg, o_err_after);
    end
    run_op(1, 1, 1, 1, 5'd5, 32'h0, 32'h40, 32'h0, 0);
    n_chk++;
    if (o_rqc != 0 || o_lat !== 1 || o_err !== 1'b1 || o_wreg !== 1'b0 ||
        o_wd !== 5'd5) begin
      n_err++;
      $display("FAIL conflict: req=%0d lat=%0d err=%b wreg=%b wd=%0d",
               o_rqc, o_lat, o_err, o_wreg, o_wd);
    end
  endtask

  task automatic test_timeout;
    run_op(1, 1, 0, 1, 5'd2, 32'h0, 32'h80, 32'h0, 1000);
    n_chk++;
    if (o_rqc != T || o_stc != T || o_lat !== T + 1) begin
      n_err++;
      $display("FAIL timeout_timing: req=%0d stall=%0d lat=%0d, need %0d/%0d/%0d",
               o_rqc, o_stc, o_lat, T, T, T + 1);
    end
    n_chk++;
    if (o_err !== 1'b1 || o_wreg !== 1'b0 || o_req_after !== 1'b0 ||
        o_err_after !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_err: err=%b wreg=%b req_after=%b err_after=%b",
               o_err, o_wreg, o_req_after, o_err_after);
    end
  endtask

  task automatic test_random;
    logic        rm, wm, wr, isbad, chkd;
    logic [4:0]  wd;
    logic [31:0] wdat, ad, rd, edat;
    int          waits, kind, elat, estc, erqc;
    logic        eerr, ewreg;
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 4));
      waits = int'($urandom_range(0, 6));
      wd = 5'($urandom); wr = 1'($urandom);
      wdat = $urandom; rd = $urandom;
      ad = $urandom & 32'hFFFF_FFFC;
      rm = (kind == 1) || (kind == 4) || (kind == 3 && wdat[0]);
      wm = (kind == 2) || (kind == 4) || (kind == 3 && !wdat[0]);
      if (kind == 3) ad[1:0] = 2'($urandom_range(1, 3));
      run_op(1, rm, wm, wr, wd, wdat, ad, rd, waits);
      isbad = (rm && wm) || ((rm || wm) && ad[1:0] != 2'b00);
      chkd = 1;
      edat = 0;
      if (!rm && !wm) begin
        elat = 1; estc = 0; erqc = 0; eerr = 0; ewreg = wr; edat = wdat;
      end else if (isbad) begin
        elat = 1; estc = 0; erqc = 0; eerr = 1; ewreg = 0; chkd = 0;
      end else if (waits < T) begin
        elat = waits + 2; estc = waits + 1; erqc = waits + 1; eerr = 0;
        ewreg = wm ? 1'b0 : wr; edat = wm ? 32'h0 : rd;
      end else begin
        elat = T + 1; estc = T; erqc = T; eerr = 1; ewreg = 0; chkd = 0;
      end
      n_chk++;
      if (o_lat != elat || o_stc != estc || o_rqc != erqc) begin
        n_err++;
        $display("FAIL rnd%0d_timing: lat=%0d stall=%0d req=%0d, need %0d/%0d/%0d",
                 i, o_lat, o_stc, o_rqc, elat, estc, erqc);
      end
      n_chk++;
      if (o_err !== eerr || o_wreg !== ewreg || o_wd !== wd ||
          (chkd && o_wdata !== edat)) begin
        n_err++;
        $display("FAIL rnd%0d_wb: err=%b wreg=%b wd=%0d data=%h, need %b/%b/%0d/%h",
                 i, o_err, o_wreg, o_wd, o_wdata, eerr, ewreg, wd, edat);
      end
      if (erqc > 0) begin
        n_chk++;
        if (!o_stable || o_raddr !== ad || o_rwe !== wm || o_rwdata !== wdat) begin
          n_err++;
          $display("FAIL rnd%0d_bus: stable=%b addr=%h we=%b wdata=%h, need %h/%b/%h",
                   i, o_stable, o_raddr, o_rwe, o_rwdata, ad, wm, wdat);
        end
      end
      n_chk++;
      if (o_wv_after !== 1'b0 || o_err_after !== 1'b0 || o_req_after !== 1'b0) begin
        n_err++;
        $display("FAIL rnd%0d_pulse: wbv=%b err=%b req=%b after retire, need 0",
                 i, o_wv_after, o_err_after, o_req_after);
      end
    end
  endtask

  task automatic test_reset_mid_busy;
    run_op(1, 0, 0, 1, 5'd1, 32'hCAFE, 32'h0, 32'h0, 0);
    in_valid = 1; rmem = 1; wmem = 0; mem_wreg = 1;
    mem_wd = 5'd6; mem_addr = 32'h200; dbus_rdata = 32'h55;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1;
    #1;
    n_chk++;
    if (dbus_req !== 1'b0 || stall_req !== 1'b0 || wb_valid !== 1'b0 ||
        wb_wreg !== 1'b0 || wb_wdata !== 32'h0 || bus_err !== 1'b0) begin
      n_err++;
      $display("FAIL rst_busy: req=%b stall=%b wbv=%b wreg=%b wdata=%h err=%b",
               dbus_req, stall_req, wb_valid, wb_wreg, wb_wdata, bus_err);
    end
    in_valid = 0; rmem = 0;
    @(posedge clk); #1;
    rst = 0;
    #3;
    dbus_ack = 1;
    @(posedge clk); #1;
    dbus_ack = 0;
    n_chk++;
    if (wb_valid !== 1'b0 || dbus_req !== 1'b0 || bus_err !== 1'b0) begin
      n_err++;
      $display("FAIL stray_ack: wbv=%b req=%b err=%b, need 0/0/0",
               wb_valid, dbus_req, bus_err);
    end
    run_op(1, 1, 0, 1, 5'd8, 32'h0, 32'h44, 32'h1357, 1);
    n_chk++;
    if (o_lat !== 3 || o_wdata !== 32'h1357 || o_wreg !== 1'b1) begin
      n_err++;
      $display("FAIL post_rst_load: lat=%0d data=%h wreg=%b, need 3/00001357/1",
               o_lat, o_wdata, o_wreg);
    end
  endtask

  initial begin
    test_reset;
    test_alu;
    test_load;
    test_store;
    test_bad;
    test_timeout;
    test_random;
    test_reset_mid_busy;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
